// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared prescaler/time base, edge or centre counting, double-buffered duty.
// Latency: pwm_out is registered and lags the counter by one clk; period_start is a one-clk registered pulse.
// Backpressure: none; duty writes are accepted on any clk, and writes to channels >= CHANNELS are dropped.
module pwm_multi #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      period,
    input  logic                  center_mode,
    input  logic [CHANNELS-1:0]   polarity,
    input  logic                  wr_en,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [WIDTH-1:0]      wr_duty,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  period_start
);

    logic [PRESCALE_W-1:0] presc_cnt;
    logic [WIDTH-1:0]      cnt;
    logic [WIDTH-1:0]      cnt_nxt;
    logic [WIDTH-1:0]      period_act;
    logic                  dir_down;
    logic                  dir_nxt;
    logic                  mode_act;
    logic                  tick;
    logic                  boundary;
    logic                  wr_hit;
    logic [WIDTH-1:0]      pending     [CHANNELS];
    logic [WIDTH-1:0]      active_duty [CHANNELS];
    logic [CHANNELS-1:0]   raw;

    // A tick is the prescaler reaching its limit; a mismatch after a prescale
    // change simply lets presc_cnt run on and wrap through zero.
    assign tick   = en && (presc_cnt == prescale);
    assign wr_hit = wr_en && (int'(wr_ch) < CHANNELS);

    // Next counter value and direction for the coming tick.
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir_down;
        if (!mode_act) begin
            if (cnt >= period_act) cnt_nxt = '0;
            else                   cnt_nxt = cnt + WIDTH'(1);
        end else if (!dir_down) begin
            if (cnt >= period_act) begin
                // Turn around at the top; a zero period never leaves 0.
                if (period_act == '0) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = period_act - WIDTH'(1);
                    dir_nxt = 1'b1;
                end
            end else begin
                cnt_nxt = cnt + WIDTH'(1);
            end
        end else begin
            if (cnt != '0) cnt_nxt = cnt - WIDTH'(1);
            else           cnt_nxt = '0;
        end
    end

    // The boundary is the tick that brings the counter back to zero.
    assign boundary = tick && (cnt_nxt == '0);

    // Time base: prescaler, counter, direction and period/mode shadow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt    <= '0;
            cnt          <= '0;
            dir_down     <= 1'b0;
            period_act   <= '0;
            mode_act     <= 1'b0;
            period_start <= 1'b0;
        end else if (!en) begin
            // Halted: hold the time base at its start and track the live settings.
            presc_cnt    <= '0;
            cnt          <= '0;
            dir_down     <= 1'b0;
            period_act   <= period;
            mode_act     <= center_mode;
            period_start <= 1'b0;
        end else begin
            presc_cnt    <= tick ? '0 : presc_cnt + PRESCALE_W'(1);
            period_start <= boundary;
            if (boundary) begin
                cnt        <= '0;
                dir_down   <= 1'b0;
                period_act <= period;
                mode_act   <= center_mode;
            end else if (tick) begin
                cnt      <= cnt_nxt;
                dir_down <= dir_nxt;
            end
        end
    end

    // Duty double buffer: writes land in pending, and are copied to active at a
    // boundary (or every clk while halted); a coinciding write bypasses pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pending[i]     <= '0;
                active_duty[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_hit && (wr_ch == CH_W'(i))) pending[i] <= wr_duty;
                if (!en || boundary) begin
                    if (wr_hit && (wr_ch == CH_W'(i))) active_duty[i] <= wr_duty;
                    else                               active_duty[i] <= pending[i];
                end
            end
        end
    end

    // Per-channel compare against the shared counter.
    always_comb begin
        raw = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            raw[i] = (cnt < active_duty[i]);
        end
    end

    // Registered outputs; halted channels sit at their inactive level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      pwm_out <= '0;
        else if (!en) pwm_out <= polarity;
        else          pwm_out <= raw ^ polarity;
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: counts high clocks and period_start pulses per window.
// Windows are aligned to period boundaries so the counts are exact.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_pwm_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] prescale;
    logic [7:0] period;
    logic       center_mode;
    logic [3:0] polarity;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_duty;
    logic [3:0] pwm_out;
    logic       period_start;

    int n_cmp = 0;
    int n_err = 0;
    int hcnt [4];
    int pscnt;

    pwm_multi #(.CHANNELS(4), .WIDTH(8), .PRESCALE_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .prescale     (prescale),
        .period       (period),
        .center_mode  (center_mode),
        .polarity     (polarity),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_duty      (wr_duty),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Single-clk duty write, entered and left on a falling edge.
    task automatic wr(input int ch, input int d);
        wr_en   = 1'b1;
        wr_ch   = ch[1:0];
        wr_duty = d[7:0];
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Run n clks; optionally write duty wd to channel wch before sample wr_i.
    task automatic win(input int n, input int wr_i, input int wch, input int wd);
        for (int c = 0; c < 4; c++) hcnt[c] = 0;
        pscnt = 0;
        for (int i = 0; i < n; i++) begin
            if (i == wr_i) begin
                wr_en   = 1'b1;
                wr_ch   = wch[1:0];
                wr_duty = wd[7:0];
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            for (int c = 0; c < 4; c++) if (pwm_out[c]) hcnt[c]++;
            if (period_start) pscnt++;
        end
        wr_en = 1'b0;
    endtask

    // Wait for a period_start sample, bounded.
    task automatic wait_ps(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (period_start) seen = 1'b1;
        end
        if (!seen) check(tag, 0, 1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; prescale = 8'd0; period = 8'd0; center_mode = 1'b0;
        polarity = 4'b0000; wr_en = 1'b0; wr_ch = 2'd0; wr_duty = 8'd0;
        @(negedge clk); @(negedge clk);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_ps", int'(period_start), 0);
        rst = 1'b0;

        // Edge mode, period 9, duties 3/5/0/255.
        period = 8'd9;
        wr(0, 3); wr(1, 5); wr(2, 0); wr(3, 255);
        @(negedge clk);
        check("idle_pwm", int'(pwm_out), 0);
        en = 1'b1;
        win(10, -1, 0, 0);
        check("edge_ch0", hcnt[0], 3);
        check("edge_ch1", hcnt[1], 5);
        check("edge_duty0", hcnt[2], 0);
        check("edge_duty255", hcnt[3], 10);
        check("edge_ps", pscnt, 1);

        // Mid-period write to ch1 (5 -> 8) at cnt=2.
        win(10, 2, 1, 8);
        check("midwr_cur", hcnt[1], 5);
        check("midwr_ps", pscnt, 1);
        win(10, -1, 0, 0);
        check("midwr_next", hcnt[1], 8);

        // Write coinciding with the boundary takes effect immediately.
        win(10, 9, 0, 7);
        check("byp_cur", hcnt[0], 3);
        win(10, -1, 0, 0);
        check("byp_next", hcnt[0], 7);

        // Polarity inverts the constant-low and constant-high channels.
        polarity = 4'b1100;
        win(10, -1, 0, 0);
        check("pol_duty0", hcnt[2], 10);
        check("pol_duty255", hcnt[3], 0);
        check("pol_ch0", hcnt[0], 7);
        polarity = 4'b0000;

        // Period change applies only at the next boundary.
        period = 8'd4;
        win(10, -1, 0, 0);
        check("per_old_ps", pscnt, 1);
        check("per_old_ch0", hcnt[0], 7);
        win(10, -1, 0, 0);
        check("per_new_ps", pscnt, 2);
        check("per_over_ch0", hcnt[0], 10);
        check("per_new_duty0", hcnt[2], 0);

        // Centre mode, period 4, duty 2: 3 of 8 ticks high.
        en = 1'b0; center_mode = 1'b1; period = 8'd4;
        wr(0, 2);
        check("halt_pwm", int'(pwm_out), 0);
        @(negedge clk);
        en = 1'b1;
        win(8, -1, 0, 0);
        check("ctr_ch0", hcnt[0], 3);
        check("ctr_ps", pscnt, 1);
        win(16, -1, 0, 0);
        check("ctr_ch0_x2", hcnt[0], 6);
        check("ctr_ps_x2", pscnt, 2);
        check("ctr_over_ch1", hcnt[1], 16);

        // Prescaler 3, period 1, duty 1: 4 clks high, 4 clks low.
        en = 1'b0; center_mode = 1'b0; prescale = 8'd3; period = 8'd1;
        wr(0, 1);
        @(negedge clk);
        en = 1'b1;
        win(8, -1, 0, 0);
        check("psc_ch0", hcnt[0], 4);
        check("psc_ps", pscnt, 1);
        win(8, -1, 0, 0);
        check("psc_ch0_b", hcnt[0], 4);
        check("psc_over_ch1", hcnt[1], 8);
        @(negedge clk);
        check("psc_mid", int'(pwm_out[0]), 1);
        en = 1'b0; polarity = 4'b1010;
        @(negedge clk);
        check("dis_pwm", int'(pwm_out), 4'b1010);
        check("dis_ps", int'(period_start), 0);

        // Asynchronous reset while running.
        polarity = 4'b0000; prescale = 8'd0; period = 8'd9;
        @(negedge clk);
        en = 1'b1;
        wait_ps("sync_pre_rst");
        @(negedge clk);
        check("pre_rst_pwm", int'(pwm_out), 4'b1011);
        #1 rst = 1'b1;
        #1;
        check("arst_pwm", int'(pwm_out), 0);
        check("arst_ps", int'(period_start), 0);
        @(negedge clk);
        rst = 1'b0;
        win(20, -1, 0, 0);
        check("post_rst_ch0", hcnt[0], 0);
        check("post_rst_ch3", hcnt[3], 0);
        check("post_rst_ps", pscnt, 2);
        wr(0, 3);
        wait_ps("sync_post_rst");
        win(10, -1, 0, 0);
        check("post_rst_wr", hcnt[0], 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
